// File: rtl/vga_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// vga_pattern_sequencer
// Frame-synchronous VGA test-pattern generator. Mode selection, auto-cycling
// and horizontal scroll are all committed on the vsync falling edge, so every
// frame is drawn with one consistent set of values.
//
// Ports:
//   Clock_25       pixel clock
//   system_resetn  asynchronous active-low reset
//   mode_sel_i     requested mode (0 auto, 1 vbars, 2 hbars, 3 checker, 4 grey)
//   scroll_en_i    advance the scroll offset by one pixel per frame
//   vsync_i        VGA vertical sync, active-low
//   pixel_x_i/y_i  current pixel coordinates
//   red_o/green_o/blue_o  registered colour, one cycle behind the coordinates
//   active_mode_o  mode latched at the last frame tick
//   frame_tick_o   one-cycle pulse on each vsync falling edge
// -----------------------------------------------------------------------------
module vga_pattern_sequencer #(
    parameter int unsigned COLOR_W         = 10,
    parameter int unsigned COORD_W         = 10,
    parameter int unsigned BAR_SHIFT       = 5,
    parameter int unsigned FRAMES_PER_STEP = 64
) (
    input  logic               Clock_25,
    input  logic               system_resetn,
    input  logic [2:0]         mode_sel_i,
    input  logic               scroll_en_i,
    input  logic               vsync_i,
    input  logic [COORD_W-1:0] pixel_x_i,
    input  logic [COORD_W-1:0] pixel_y_i,
    output logic [COLOR_W-1:0] red_o,
    output logic [COLOR_W-1:0] green_o,
    output logic [COLOR_W-1:0] blue_o,
    output logic [2:0]         active_mode_o,
    output logic               frame_tick_o
);

    localparam int unsigned CNT_W  = $clog2(FRAMES_PER_STEP + 1);
    localparam int unsigned WIDE_W = COORD_W + COLOR_W;
    localparam int unsigned B0     = BAR_SHIFT;
    localparam int unsigned B1     = BAR_SHIFT + 1;
    localparam int unsigned B2     = BAR_SHIFT + 2;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(FRAMES_PER_STEP - 1);

    logic               vsync_q;
    logic [2:0]         active_mode_q, active_mode_d;
    logic [2:0]         auto_idx_q,    auto_idx_d;
    logic [CNT_W-1:0]   step_cnt_q,    step_cnt_d;
    logic [COORD_W-1:0] scroll_off_q,  scroll_off_d;
    logic [COLOR_W-1:0] red_q,   red_d;
    logic [COLOR_W-1:0] green_q, green_d;
    logic [COLOR_W-1:0] blue_q,  blue_d;

    logic [2:0]         pattern;
    logic [COORD_W-1:0] x_eff;
    logic [WIDE_W-1:0]  grey_wide;
    logic               unused_y;

    // Falling edge of the registered vsync marks the start of a new frame.
    assign frame_tick_o = vsync_q & ~vsync_i;

    // Y bits outside the three-bit bar window are intentionally ignored.
    assign unused_y = ^pixel_y_i;

    // Frame-rate state: mode latch, auto sequencer and scroll offset.
    always_comb begin
        active_mode_d = active_mode_q;
        auto_idx_d    = auto_idx_q;
        step_cnt_d    = step_cnt_q;
        scroll_off_d  = scroll_off_q;
        if (frame_tick_o) begin
            active_mode_d = mode_sel_i;
            if (scroll_en_i) begin
                scroll_off_d = scroll_off_q + COORD_W'(1);
            end
            if (mode_sel_i != 3'd0) begin
                step_cnt_d = '0;
            end else if (active_mode_q != 3'd0) begin
                // Resume auto from the pattern just shown, without advancing.
                step_cnt_d = '0;
                auto_idx_d = (active_mode_q >= 3'd1 && active_mode_q <= 3'd4)
                             ? active_mode_q : 3'd1;
            end else if (step_cnt_q == LAST_STEP) begin
                step_cnt_d = '0;
                auto_idx_d = (auto_idx_q == 3'd4) ? 3'd1 : auto_idx_q + 3'd1;
            end else begin
                step_cnt_d = step_cnt_q + CNT_W'(1);
            end
        end
    end

    // Pixel-rate colour generation from the frame-latched state.
    always_comb begin
        pattern   = (active_mode_q == 3'd0) ? auto_idx_q : active_mode_q;
        x_eff     = pixel_x_i + scroll_off_q;
        // MSB-align x_eff: zero-pads when COLOR_W is wider, truncates otherwise.
        grey_wide = {x_eff, {COLOR_W{1'b0}}};
        red_d     = '0;
        green_d   = '0;
        blue_d    = '0;
        case (pattern)
            3'd1: begin
                red_d   = {COLOR_W{~x_eff[B2]}};
                green_d = {COLOR_W{~x_eff[B1]}};
                blue_d  = {COLOR_W{~x_eff[B0]}};
            end
            3'd2: begin
                red_d   = {COLOR_W{~pixel_y_i[B2]}};
                green_d = {COLOR_W{~pixel_y_i[B1]}};
                blue_d  = {COLOR_W{~pixel_y_i[B0]}};
            end
            3'd3: begin
                red_d   = {COLOR_W{~x_eff[B2] ^ ~pixel_y_i[B2]}};
                green_d = {COLOR_W{~x_eff[B1] ^ ~pixel_y_i[B1]}};
                blue_d  = {COLOR_W{~x_eff[B0] ^ ~pixel_y_i[B0]}};
            end
            3'd4: begin
                red_d   = grey_wide[WIDE_W-1 -: COLOR_W];
                green_d = grey_wide[WIDE_W-1 -: COLOR_W];
                blue_d  = grey_wide[WIDE_W-1 -: COLOR_W];
            end
            default: begin
                red_d   = '0;
                green_d = '0;
                blue_d  = '0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge Clock_25 or negedge system_resetn) begin
        if (!system_resetn) begin
            vsync_q       <= 1'b0;
            active_mode_q <= 3'd0;
            auto_idx_q    <= 3'd1;
            step_cnt_q    <= '0;
            scroll_off_q  <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            vsync_q       <= vsync_i;
            active_mode_q <= active_mode_d;
            auto_idx_q    <= auto_idx_d;
            step_cnt_q    <= step_cnt_d;
            scroll_off_q  <= scroll_off_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    assign red_o         = red_q;
    assign green_o       = green_q;
    assign blue_o        = blue_q;
    assign active_mode_o = active_mode_q;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vga_pattern_sequencer
// Self-checking bench: directed vector table, hand-written frame sequences for
// auto cycling / return-to-auto / scroll wrap / mid-frame reset, and random
// stimulus checked every cycle against a frame-level behavioural model.
// -----------------------------------------------------------------------------
module tb_vga_pattern_sequencer;

    localparam int unsigned CW  = 10;
    localparam int unsigned XW  = 10;
    localparam int unsigned BS  = 5;
    localparam int unsigned FPS = 2;
    localparam int          FULL = (1 << CW) - 1;

    logic          Clock_25 = 1'b0;
    logic          system_resetn;
    logic [2:0]    mode_sel_i;
    logic          scroll_en_i;
    logic          vsync_i;
    logic [XW-1:0] pixel_x_i;
    logic [XW-1:0] pixel_y_i;
    logic [CW-1:0] red_o, green_o, blue_o;
    logic [2:0]    active_mode_o;
    logic          frame_tick_o;

    vga_pattern_sequencer #(
        .COLOR_W(CW), .COORD_W(XW), .BAR_SHIFT(BS), .FRAMES_PER_STEP(FPS)
    ) dut (
        .Clock_25(Clock_25), .system_resetn(system_resetn),
        .mode_sel_i(mode_sel_i), .scroll_en_i(scroll_en_i), .vsync_i(vsync_i),
        .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i),
        .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
        .active_mode_o(active_mode_o), .frame_tick_o(frame_tick_o)
    );

    always #20 Clock_25 = ~Clock_25;

    int n_checks = 0;
    int n_pass   = 0;
    int dut_ticks = 0;

    // Frame-level reference state.
    int m_vq, m_mode, m_idx, m_cnt, m_scroll;

    typedef struct {
        logic [2:0] mode;
        int x;
        int y;
        int r;
        int g;
        int b;
    } vec_t;
    vec_t vecs[10];

    // Expected colours for patterns 1..4 at x=32, y=0 (no scroll).
    int pc_r[5];
    int pc_g[5];
    int pc_b[5];
    int auto_seq[9];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int bitof(input int v, input int k);
        return (v >> k) & 1;
    endfunction

    function automatic int rep(input int b);
        return (b != 0) ? FULL : 0;
    endfunction

    task automatic model_rgb(input int p, input int x, input int y, input int s,
                             output int r, output int g, output int b);
        int xe;
        xe = (x + s) % (1 << XW);
        r = 0; g = 0; b = 0;
        case (p)
            1: begin r = rep(1 - bitof(xe, BS+2)); g = rep(1 - bitof(xe, BS+1)); b = rep(1 - bitof(xe, BS)); end
            2: begin r = rep(1 - bitof(y, BS+2));  g = rep(1 - bitof(y, BS+1));  b = rep(1 - bitof(y, BS));  end
            3: begin
                r = rep((1 - bitof(xe, BS+2)) ^ (1 - bitof(y, BS+2)));
                g = rep((1 - bitof(xe, BS+1)) ^ (1 - bitof(y, BS+1)));
                b = rep((1 - bitof(xe, BS))   ^ (1 - bitof(y, BS)));
            end
            4: begin r = xe; g = xe; b = xe; end
            default: begin r = 0; g = 0; b = 0; end
        endcase
    endtask

    task automatic model_tick(input int sel, input int sen);
        if (sel == 0) begin
            if (m_mode == 0) begin
                if (m_cnt == FPS - 1) begin
                    m_cnt = 0;
                    m_idx = (m_idx % 4) + 1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                m_cnt = 0;
                m_idx = (m_mode >= 1 && m_mode <= 4) ? m_mode : 1;
            end
        end else begin
            m_cnt = 0;
        end
        if (sen != 0) m_scroll = (m_scroll + 1) % (1 << XW);
        m_mode = sel;
    endtask

    // One clock cycle with the current inputs; checks tick, colour and mode.
    task automatic cycle();
        int er, eg, eb, p, tick;
        @(negedge Clock_25);
        tick = (m_vq == 1 && vsync_i == 1'b0) ? 1 : 0;
        check("frame_tick", int'(frame_tick_o), tick);
        dut_ticks += int'(frame_tick_o);
        p = (m_mode == 0) ? m_idx : m_mode;
        model_rgb(p, int'(pixel_x_i), int'(pixel_y_i), m_scroll, er, eg, eb);
        @(posedge Clock_25);
        if (tick == 1) model_tick(int'(mode_sel_i), int'(scroll_en_i));
        m_vq = int'(vsync_i);
        #1;
        check("red", int'(red_o), er);
        check("green", int'(green_o), eg);
        check("blue", int'(blue_o), eb);
        check("active_mode", int'(active_mode_o), m_mode);
    endtask

    // One vsync pulse: high, falling edge (tick), held low for a cycle.
    task automatic frame();
        vsync_i = 1'b1; cycle();
        vsync_i = 1'b0; cycle();
        cycle();
        vsync_i = 1'b1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        @(negedge Clock_25);
        #5 system_resetn = 1'b0;
        #1;
        check("rst_red", int'(red_o), 0);
        check("rst_blue", int'(blue_o), 0);
        check("rst_mode", int'(active_mode_o), 0);
        check("rst_tick", int'(frame_tick_o), 0);
        m_vq = 0; m_mode = 0; m_idx = 1; m_cnt = 0; m_scroll = 0;
        @(posedge Clock_25);
        #1 system_resetn = 1'b1;
    endtask

    task automatic check_pat(input string name, input int p);
        check({name, "_r"}, int'(red_o), pc_r[p]);
        check({name, "_g"}, int'(green_o), pc_g[p]);
        check({name, "_b"}, int'(blue_o), pc_b[p]);
    endtask

    initial begin
        int t0;
        vecs[0] = '{3'd1,   0,   0, 'h3FF, 'h3FF, 'h3FF};
        vecs[1] = '{3'd1, 224,   0, 'h000, 'h000, 'h000};
        vecs[2] = '{3'd1, 224, 500, 'h000, 'h000, 'h000};
        vecs[3] = '{3'd1,  32,   0, 'h3FF, 'h3FF, 'h000};
        vecs[4] = '{3'd2,   0,  64, 'h3FF, 'h000, 'h3FF};
        vecs[5] = '{3'd3,  32,  32, 'h000, 'h000, 'h000};
        vecs[6] = '{3'd3,  32,   0, 'h000, 'h000, 'h3FF};
        vecs[7] = '{3'd4, 'h155, 9, 'h155, 'h155, 'h155};
        vecs[8] = '{3'd5,   0,   0, 'h000, 'h000, 'h000};
        vecs[9] = '{3'd7, 100, 100, 'h000, 'h000, 'h000};
        pc_r = '{0, 'h3FF, 'h3FF, 'h000, 'h020};
        pc_g = '{0, 'h3FF, 'h3FF, 'h000, 'h020};
        pc_b = '{0, 'h000, 'h3FF, 'h3FF, 'h020};
        auto_seq = '{1, 1, 2, 2, 3, 3, 4, 4, 1};

        system_resetn = 1'b1;
        mode_sel_i = 3'd5; scroll_en_i = 1'b0; vsync_i = 1'b0;
        pixel_x_i = '0; pixel_y_i = '0;

        // Reset and black level.
        do_reset();
        t0 = dut_ticks;
        frame();
        check("reset_tick_count", dut_ticks - t0, 1);
        check("reset_mode5", int'(active_mode_o), 5);
        for (int i = 0; i < 4; i++) begin
            pixel_x_i = XW'(i * 300); pixel_y_i = XW'(i * 150 + 7);
            cycle();
            check("black", int'(red_o | green_o | blue_o), 0);
        end

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            mode_sel_i = vecs[i].mode;
            frame();
            pixel_x_i = XW'(vecs[i].x); pixel_y_i = XW'(vecs[i].y);
            cycle();
            check($sformatf("vec%0d_r", i), int'(red_o), vecs[i].r);
            check($sformatf("vec%0d_g", i), int'(green_o), vecs[i].g);
            check($sformatf("vec%0d_b", i), int'(blue_o), vecs[i].b);
        end

        // Auto cycling from reset.
        mode_sel_i = 3'd0; pixel_x_i = XW'(32); pixel_y_i = '0;
        do_reset();
        cycle();
        check_pat("auto_f0", auto_seq[0]);
        for (int k = 1; k <= 8; k++) begin
            frame();
            check_pat($sformatf("auto_f%0d", k), auto_seq[k]);
        end

        // Return to auto after a manual mode.
        mode_sel_i = 3'd3;
        for (int k = 0; k < 5; k++) begin
            frame();
            check_pat("manual3", 3);
        end
        mode_sel_i = 3'd0;
        frame(); check_pat("reenter_f1", 3);
        frame(); check_pat("reenter_f2", 3);
        frame(); check_pat("reenter_f3", 4);

        // Mid-frame mode toggle without vsync has no effect.
        vsync_i = 1'b1;
        mode_sel_i = 3'd2; cycle(); cycle(); cycle();
        check("midframe_mode", int'(active_mode_o), 0);
        mode_sel_i = 3'd0; cycle();
        check_pat("midframe_pat", 4);

        // Entering auto from a reserved mode restarts at pattern 1.
        mode_sel_i = 3'd5; frame();
        mode_sel_i = 3'd0; frame();
        check_pat("from_reserved", 1);

        // Scroll wrap over 1025 frames in grey mode.
        do_reset();
        mode_sel_i = 3'd4; scroll_en_i = 1'b1;
        for (int k = 0; k < 1025; k++) frame();
        scroll_en_i = 1'b0;
        pixel_x_i = XW'(1023); cycle();
        check("wrap_x1023", int'(red_o), 'h000);
        pixel_x_i = '0; cycle();
        check("wrap_x0", int'(green_o), 'h001);
        for (int k = 0; k < 3; k++) frame();
        cycle();
        check("scroll_hold", int'(blue_o), 'h001);

        // Mid-frame reset with non-zero outputs.
        pixel_x_i = XW'(200); cycle();
        do_reset();
        check("post_rst_pattern_idx", (m_mode == 0 && m_idx == 1) ? 1 : 0, 1);

        // Randomised stimulus against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) vsync_i = ~vsync_i;
            if ($urandom_range(0, 15) == 0) mode_sel_i = 3'($urandom_range(0, 7));
            scroll_en_i = 1'($urandom_range(0, 1));
            pixel_x_i = XW'($urandom_range(0, 1023));
            pixel_y_i = XW'($urandom_range(0, 1023));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
